// File: rtl/inequality_tally_if.sv
// Handshake and report bus between the inequality stage, the tally block and its consumer.
// The slave modport is the tally block itself.
interface inequality_tally_if #(
  parameter int unsigned CNT_W = 4
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [2:0]       CLS;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [CNT_W-1:0] GT_CNT;
  logic [CNT_W-1:0] EQ_CNT;
  logic [CNT_W-1:0] LT_CNT;
  logic [CNT_W-1:0] ERR_CNT;
  logic [2:0]       MAJ;

  modport master (
    output IN_VALID, CLS, OUT_READY,
    input  IN_READY, OUT_VALID, GT_CNT, EQ_CNT, LT_CNT, ERR_CNT, MAJ
  );

  modport slave (
    input  IN_VALID, CLS, OUT_READY,
    output IN_READY, OUT_VALID, GT_CNT, EQ_CNT, LT_CNT, ERR_CNT, MAJ
  );
endinterface

// File: rtl/inequality_tally.sv
// Counts greater/equal/less/invalid class codes over a window of WINDOW samples and
// reports the counts plus the one-hot majority class through a valid/ready handshake.
module inequality_tally #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = 4
) (
  input logic               CLK,
  input logic               RST,
  inequality_tally_if.slave bus
);
  localparam int unsigned SC_W = $clog2(WINDOW + 1);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] gt_q, eq_q, lt_q, err_q;
  logic [CNT_W-1:0] gt_d, eq_d, lt_d, err_d;
  logic [SC_W-1:0]  smp_q;
  logic [CNT_W-1:0] gt_out_q, eq_out_q, lt_out_q, err_out_q;
  logic [2:0]       maj_q, maj_d;
  logic             last_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Counts including the sample currently on CLS, so the WINDOW-th sample lands in the report.
  always_comb begin
    gt_d  = gt_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    err_d = err_q;
    case (bus.CLS)
      3'b100:  gt_d  = sat_inc(gt_q);
      3'b010:  eq_d  = sat_inc(eq_q);
      3'b001:  lt_d  = sat_inc(lt_q);
      default: err_d = sat_inc(err_q);
    endcase

    maj_d = 3'b000;
    if (gt_d == '0 && eq_d == '0 && lt_d == '0) begin
      maj_d = 3'b000;
    end else if (gt_d >= eq_d && gt_d >= lt_d) begin
      maj_d = 3'b100;
    end else if (eq_d >= lt_d) begin
      maj_d = 3'b010;
    end else begin
      maj_d = 3'b001;
    end

    last_d = (smp_q == SC_W'(WINDOW - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ACCUM;
      gt_q      <= '0;
      eq_q      <= '0;
      lt_q      <= '0;
      err_q     <= '0;
      smp_q     <= '0;
      gt_out_q  <= '0;
      eq_out_q  <= '0;
      lt_out_q  <= '0;
      err_out_q <= '0;
      maj_q     <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.IN_VALID) begin
            gt_q  <= gt_d;
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            err_q <= err_d;
            smp_q <= smp_q + SC_W'(1);
            if (last_d) begin
              state_q   <= REPORT;
              gt_out_q  <= gt_d;
              eq_out_q  <= eq_d;
              lt_out_q  <= lt_d;
              err_out_q <= err_d;
              maj_q     <= maj_d;
            end
          end
        end
        REPORT: begin
          if (bus.OUT_READY) begin
            state_q   <= ACCUM;
            gt_q      <= '0;
            eq_q      <= '0;
            lt_q      <= '0;
            err_q     <= '0;
            smp_q     <= '0;
            gt_out_q  <= '0;
            eq_out_q  <= '0;
            lt_out_q  <= '0;
            err_out_q <= '0;
            maj_q     <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.IN_READY  = (state_q == ACCUM);
  assign bus.OUT_VALID = (state_q == REPORT);
  assign bus.GT_CNT    = gt_out_q;
  assign bus.EQ_CNT    = eq_out_q;
  assign bus.LT_CNT    = lt_out_q;
  assign bus.ERR_CNT   = err_out_q;
  assign bus.MAJ       = maj_q;
endmodule

// File: doc/inequality_tally.md
INEQUALITY_TALLY -- requirements
Module: inequality_tally

Interface
REQ-001 The module SHALL have parameter WINDOW, default 8, meaning the number of accepted samples per report (legal range 1..255).
REQ-002 The module SHALL have parameter CNT_W, default 4, meaning the width of each count output; it SHALL satisfy WINDOW <= 2^CNT_W - 1.
REQ-003 CLK  input  1  the only clock; all state updates occur on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 IN_VALID  input  1  a sample is present on CLS.
REQ-006 IN_READY  output  1  the block can accept a sample this cycle.
REQ-007 CLS  input  3  class code from the upstream inequality stage: [2] greater, [1] equal, [0] less; legal codes are one-hot.
REQ-008 OUT_VALID  output  1  a window report is present on the count outputs.
REQ-009 OUT_READY  input  1  the downstream stage accepts the report.
REQ-010 GT_CNT, EQ_CNT, LT_CNT  output  CNT_W each  number of greater, equal and less samples in the reported window.
REQ-011 ERR_CNT  output  CNT_W  number of non-one-hot samples in the reported window.
REQ-012 MAJ  output  3  one-hot majority class of the reported window, using the CLS bit order.

Function
REQ-013 The block SHALL have two states: ACCUM and REPORT.
REQ-014 In ACCUM, IN_READY SHALL be 1 and OUT_VALID SHALL be 0; in REPORT, IN_READY SHALL be 0 and OUT_VALID SHALL be 1.
REQ-015 IN_READY and OUT_VALID SHALL be decoded from registered state only, with no combinational path from any input.
REQ-016 A sample SHALL be accepted on an edge where the state is ACCUM and IN_VALID=1.
REQ-017 Accepting a sample SHALL increment exactly one internal counter: GT for code 100, EQ for 010, LT for 001, and ERR for any other code (000, 011, 101, 110, 111).
REQ-018 Accepting a sample SHALL increment an internal sample counter of width ceil(log2(WINDOW+1)).
REQ-019 When the accepted sample is the WINDOW-th of the window, the next state SHALL be REPORT.
REQ-020 OUT_VALID SHALL rise on the edge that accepts the WINDOW-th sample (latency 0 cycles after that edge).
REQ-021 On that same edge, the outputs SHALL be loaded with the final counts, which include the WINDOW-th sample.
REQ-022 Each count SHALL saturate at 2^CNT_W - 1; saturation is unreachable when REQ-002 holds, and wrap-around SHALL never occur.
REQ-023 MAJ SHALL be the one-hot code of the largest of the GT, EQ and LT counts; ERR is not a candidate.
REQ-024 MAJ ties SHALL be resolved by priority GT > EQ > LT.
REQ-025 MAJ SHALL be 000 when GT, EQ and LT are all 0.
REQ-026 MAJ SHALL be registered together with the counts.
REQ-027 In REPORT, all report outputs SHALL hold stable until OUT_READY=1.
REQ-028 On the edge with REPORT and OUT_READY=1, the state SHALL return to ACCUM.
REQ-029 On that same edge, all internal counters and the sample counter SHALL clear.
REQ-030 On that same edge, the report outputs SHALL clear to 0.
REQ-031 The first sample of the next window SHALL be accepted no earlier than the edge after that handshake (one bubble cycle minimum).
REQ-032 IN_VALID and CLS SHALL be ignored while in REPORT; no sample is lost, because IN_READY=0.
REQ-033 When IN_VALID=0 in ACCUM, all state SHALL be held.
REQ-034 With WINDOW=1, every accepted sample SHALL produce a report.

Reset
REQ-035 On an edge with RST=1, the state SHALL become ACCUM.
REQ-036 On an edge with RST=1, all internal counters and the sample counter SHALL become 0.
REQ-037 On an edge with RST=1, the outputs SHALL become OUT_VALID=0, GT_CNT=EQ_CNT=LT_CNT=ERR_CNT=0 and MAJ=000.
REQ-038 IN_READY SHALL be 1 from the first edge after RST is released.
REQ-039 RST SHALL take priority over any simultaneous sample acceptance or report handshake.
REQ-040 A reset mid-window or mid-report SHALL discard the partial window or pending report; the next window starts from count 0.

Verification (WINDOW=8, CNT_W=4)
REQ-041 Reset: hold RST=1 for 2 cycles, then release -> all outputs 0, MAJ=000, OUT_VALID=0; IN_READY=1 on the first edge after release.
REQ-042 Mixed window: 8 back-to-back samples 100,100,100,010,001,001,100,000 with OUT_READY=0 -> OUT_VALID rises on the 8th accepting edge with GT=4, EQ=1, LT=2, ERR=1, MAJ=100; outputs are stable for 5 held cycles.
REQ-043 Tie and back-pressure: 4 samples of 010 and 4 samples of 001, with IN_VALID gaps inserted -> EQ=4, LT=4, MAJ=010; IN_VALID=1 with CLS=100 while in REPORT -> no count changes.
REQ-044 Handshake: assert OUT_READY for 1 cycle -> OUT_VALID=0 and outputs 0 on the next edge; IN_READY=1.
REQ-045 Next window: send 8 samples of 111 -> ERR=8, GT=EQ=LT=0, MAJ=000.
REQ-046 Mid-window reset: assert RST after 5 accepted samples, release, then send 8 samples of 001 -> LT=8, MAJ=001, with no residue from the discarded 5 samples.
